// File: rtl/alu_result_stage.sv
// alu_result_stage: EX->MEM boundary register with a two-entry skid buffer.
// Captures the ALU result and flags, resolves BEQ/BNE, suppresses the register
// write on signed overflow or a reserved op_code, and raises sticky exception
// flags. Output side is a valid/ready handshake; in_ready is registered.
//
// Optional feature: define ALU_RESULT_STAT_EN to add saturating statistics
// counters stat_retired / stat_exc (width CNT_W).
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid / in_ready            upstream handshake
//   Z, overflow, equal, zero       ALU result and flags
//   op_code, br_type, br_target    op code, branch kind, branch target
//   rd, we                         destination register and write request
//   out_valid / out_ready          downstream handshake
//   out_result, out_rd, out_we,
//   out_zero                       captured entry (main slot)
//   br_taken, br_addr              taken-branch pulse and held target
//   exc_ovf, exc_illegal           sticky exception flags
//   exc_clear                      clears sticky flags (set wins)
//   stat_retired, stat_exc         statistics (ALU_RESULT_STAT_EN only)
module alu_result_stage #(
    parameter int unsigned N    = 32,
    parameter int unsigned RD_W = 5
`ifdef ALU_RESULT_STAT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    Z,
    input  logic            overflow,
    input  logic            equal,
    input  logic            zero,
    input  logic [3:0]      op_code,
    input  logic [1:0]      br_type,
    input  logic [N-1:0]    br_target,
    input  logic [RD_W-1:0] rd,
    input  logic            we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_we,
    output logic            out_zero,
    output logic            br_taken,
    output logic [N-1:0]    br_addr,
    output logic            exc_ovf,
    output logic            exc_illegal,
    input  logic            exc_clear
`ifdef ALU_RESULT_STAT_EN
    ,
    output logic [CNT_W-1:0] stat_retired,
    output logic [CNT_W-1:0] stat_exc
`endif
);

    localparam logic [3:0] OP_ADD         = 4'b0101;
    localparam logic [3:0] OP_SUB         = 4'b0110;
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd11;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;

    logic            accept;
    logic            deliver;
    logic            illegal;
    logic            ovf;
    logic            is_branch;
    logic            taken;
    logic            in_we;
    logic [N-1:0]    in_result;

    logic [N-1:0]    skid_result;
    logic [RD_W-1:0] skid_rd;
    logic            skid_we;
    logic            skid_zero;

    // Handshake events and per-entry decode of the incoming ALU result
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign illegal   = (op_code >= OP_ILLEGAL_MIN);
    assign ovf       = overflow & ((op_code == OP_ADD) | (op_code == OP_SUB));
    assign is_branch = (br_type == 2'b01) | (br_type == 2'b10);
    assign taken     = ((br_type == 2'b01) & equal) | ((br_type == 2'b10) & ~equal);
    assign in_we     = we & ~ovf & ~illegal & ~is_branch;
    assign in_result = illegal ? '0 : Z;

    // Skid-buffer state machine; main slot drives the out_* ports directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            out_result  <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
            out_zero    <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_we     <= 1'b0;
            skid_zero   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_result <= in_result;
                        out_rd     <= rd;
                        out_we     <= in_we;
                        out_zero   <= zero;
                        state      <= ONE;
                        out_valid  <= 1'b1;
                        in_ready   <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        out_result <= in_result;
                        out_rd     <= rd;
                        out_we     <= in_we;
                        out_zero   <= zero;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry behind main
                        skid_result <= in_result;
                        skid_rd     <= rd;
                        skid_we     <= in_we;
                        skid_zero   <= zero;
                        state       <= TWO;
                        in_ready    <= 1'b0;
                    end else if (deliver) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        out_result <= skid_result;
                        out_rd     <= skid_rd;
                        out_we     <= skid_we;
                        out_zero   <= skid_zero;
                        state      <= ONE;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Branch pulse and held target, independent of downstream stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_taken <= 1'b0;
            br_addr  <= '0;
        end else begin
            br_taken <= accept & taken;
            if (accept && taken) begin
                br_addr <= br_target;
            end
        end
    end

    // Sticky exception flags; a same-cycle set overrides the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_ovf     <= 1'b0;
            exc_illegal <= 1'b0;
        end else begin
            if (accept && ovf) begin
                exc_ovf <= 1'b1;
            end else if (exc_clear) begin
                exc_ovf <= 1'b0;
            end
            if (accept && illegal) begin
                exc_illegal <= 1'b1;
            end else if (exc_clear) begin
                exc_illegal <= 1'b0;
            end
        end
    end

`ifdef ALU_RESULT_STAT_EN
    // Saturating statistics; clear takes priority over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_retired <= '0;
            stat_exc     <= '0;
        end else if (exc_clear) begin
            stat_retired <= '0;
            stat_exc     <= '0;
        end else begin
            if (deliver && (stat_retired != '1)) begin
                stat_retired <= stat_retired + CNT_W'(1);
            end
            if (accept && (ovf || illegal) && (stat_exc != '1)) begin
                stat_exc <= stat_exc + CNT_W'(1);
            end
        end
    end
`endif

endmodule
